// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the register file slice.
//   rf_state_e : sequencer state (CLEAR sweeps storage to zero, RUN serves rd/wt)
//   RF_DATA_W  : default word width
//   RF_DEPTH   : default number of registers
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 16;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: post-reset clear sequencer. Walks clr_ptr over every entry,
// one per cycle, asking the storage array to write zero, then parks in RUN.
// The sweep ignores the global enable so ready always rises DEPTH edges after
// reset is released.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (restarts the sweep)
//   clr_we   out  write zero to clr_addr at the next edge
//   clr_addr out  entry being cleared
//   ready    out  sweep finished, user rd/wt accepted
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    if (state == CLEAR) begin
      clr_we      = 1'b1;
      clr_ptr_nxt = clr_ptr + 1'b1;
      if (clr_ptr == LAST) state_nxt = RUN;
    end
  end

  assign clr_addr = clr_ptr;
  assign ready    = (state == RUN);

endmodule

// File: rtl/regfile_param.sv
// regfile_param: DEPTH x DATA_W register file, one write port, two registered
// read ports with write-first forwarding. After reset a sweep zeroes every
// entry before rd/wt are accepted (ready).
// Optional feature macro: REGFILE_ZERO_REG_EN -- register 0 reads as zero and
// writes to it are discarded.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          global enable (freezes storage and outputs when low)
//   rd, so1/so2 read request and indices
//   wt, si, ip  write request, index, data
//   op1/op2     registered read data
//   op_vld      op1/op2 updated at the last edge
//   ready       clear sweep done
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd,
  input  logic              wt,
  input  logic [ADDR_W-1:0] si,
  input  logic [DATA_W-1:0] ip,
  input  logic [ADDR_W-1:0] so1,
  input  logic [ADDR_W-1:0] so2,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              op_vld,
  output logic              ready
);

  logic [DATA_W-1:0] rfile [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic [DATA_W-1:0] fwd1, fwd2;

  regfile_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Indices beyond DEPTH-1 exist only for non power-of-two depths.
  function automatic logic in_range(input logic [ADDR_W-1:0] x);
    return int'(x) < DEPTH;
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] x);
`ifdef REGFILE_ZERO_REG_EN
    return in_range(x) && (x != '0);
`else
    return in_range(x);
`endif
  endfunction

  // Write-first: a same-edge write to the read index wins over storage.
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] x);
    if (!in_range(x)) return '0;
`ifdef REGFILE_ZERO_REG_EN
    if (x == '0) return '0;
`endif
    if (wt && si == x) return ip;
    return rfile[x];
  endfunction

  assign user_we = ready && en && wt && writable(si);

  always_comb begin
    fwd1 = fwd(so1);
    fwd2 = fwd(so2);
  end

  // The sweep owns the array while not ready, so the two writers never
  // collide; the sweep is still listed first.
  always_ff @(posedge clk) begin
    if (clr_we)       rfile[clr_addr] <= '0;
    else if (user_we) rfile[si]       <= ip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1    <= '0;
      op2    <= '0;
      op_vld <= 1'b0;
    end else if (ready && en) begin
      op_vld <= rd;
      if (rd) begin
        op1 <= fwd1;
        op2 <= fwd2;
      end
    end else begin
      op_vld <= 1'b0;
    end
  end

endmodule
